arranque_carrera_n: RTL and testbench
=====================================

// Module: arranque_carrera_n
// PURPOSE
//  Parametrised race-start sequencer for N lanes. Drives the lamp/horn outputs A (marks), L (ready),
//  Y (go) and B (horn) through timed phases, and detects false starts per lane from a sensor vector.
//  Latches the offending lanes and counts false starts, with an optional auto-retry mode.
//  Sits between the lane sensors and the starter lamps/horn driver.
// PARAMETERS
//  N_CARRILES     4   number of lanes (>=1)
//  CNT_W          16  phase-timer width
//  T_PUESTOS      4   cycles in PUESTOS (1..2^CNT_W)
//  T_LISTOS       6   cycles in LISTOS (1..2^CNT_W)
//  T_YA           2   cycles in YA (1..2^CNT_W)
//  T_BOCINA       3   cycles in BOCINA (1..2^CNT_W)
//  MAX_FALSAS     2   false starts allowed before abort (>=1)
//  AUTO_REINTENTO 0   0: BOCINA->REPOSO; 1: BOCINA->PUESTOS until abort
// PORTS
//  clk          in   1                   clock, rising edge
//  reset        in   1                   synchronous, active-high
//  inicio       in   1                   start request, sampled only in REPOSO
//  falsa        in   N_CARRILES          per-lane early-movement sensor
//  habilitado   in   N_CARRILES          lane enable mask; disabled lanes ignored
//  A,L,Y,B      out  1 each              marks / ready / go / horn lamps
//  estado       out  3                   0 REPOSO,1 PUESTOS,2 LISTOS,3 YA,4 BOCINA
//  carril_falso out  N_CARRILES          sticky lanes that false-started
//  num_falsas   out  $clog2(MAX_FALSAS+1) false starts this race, saturating
//  valida       out  1                   high in first YA cycle only
//  abortada     out  1                   sticky: race aborted on MAX_FALSAS
// BEHAVIOUR
//  Single clock domain; reset is synchronous and active-high.
//  Reset (any state, mid-phase too): next edge -> REPOSO; timer, carril_falso, num_falsas, abortada = 0.
//  Outputs are Moore/registered: after reset, A=L=Y=B=0, estado=0, valida=0.
//  Lamps: PUESTOS A=1; LISTOS L=1; YA Y=1; BOCINA B=1; otherwise 0. Exactly one lamp high at a time.
//  Timer: loaded with T_x-1 on entry; decrements each cycle; exit when 0 -> each phase lasts T_x cycles.
//  REPOSO: inicio=1 -> PUESTOS; same edge clears carril_falso, num_falsas, abortada. Otherwise hold.
//  PUESTOS, LISTOS: f = falsa & habilitado sampled every cycle.
//   f!=0 -> BOCINA next; carril_falso |= f; num_falsas += 1 (saturating at MAX_FALSAS).
//   f==0 at timer 0 -> PUESTOS->LISTOS, LISTOS->YA.
//   False start overrides timer expiry in the same cycle.
//  YA: falsa ignored; valida=1 in first cycle; at timer 0 -> REPOSO.
//  BOCINA: falsa ignored; at timer 0:
//   AUTO_REINTENTO=0 -> REPOSO.
//   AUTO_REINTENTO=1 and num_falsas<MAX_FALSAS -> PUESTOS; carril_falso is kept.
//   AUTO_REINTENTO=1 and num_falsas==MAX_FALSAS -> REPOSO; abortada=1.
//  inicio outside REPOSO: ignored. habilitado=0 everywhere: no false start is ever detected.
//  Unused estado encodings (5-7) -> REPOSO next edge, lamps 0.
// TESTING (defaults unless noted)
//  Clean start: inicio=1 one cycle, falsa=0 -> A high 4 cycles, L 6, Y 2 (valida in first), then REPOSO; num_falsas=0.
//  False start: falsa=4'b0100 in LISTOS cycle 3 -> B next cycle for 3 cycles, carril_falso=0100, num_falsas=1, then REPOSO.
//  Masking/race: habilitado=1011, falsa=0100 -> ignored; falsa=0001 in last LISTOS cycle -> BOCINA, not YA.
//  AUTO_REINTENTO=1: false start twice -> PUESTOS after 1st BOCINA; REPOSO after 2nd; abortada=1, num_falsas=2.
//  Reset mid-LISTOS -> REPOSO next edge, all outputs 0; new inicio clears sticky flags and restarts at PUESTOS.
//  T_*=1 all -> each phase exactly 1 cycle; inicio held in YA -> no restart until REPOSO.

Source files
------------

// File: rtl/arranque_carrera_n.sv
// Race-start sequencer: walks the starter lamps through PUESTOS/LISTOS/YA, sounds the horn on a
// false start, latches the offending lanes and optionally retries until too many false starts.
module arranque_carrera_n #(
   parameter int N_CARRILES     = 4,
   parameter int CNT_W          = 16,
   parameter int T_PUESTOS      = 4,
   parameter int T_LISTOS       = 6,
   parameter int T_YA           = 2,
   parameter int T_BOCINA       = 3,
   parameter int MAX_FALSAS     = 2,
   parameter int AUTO_REINTENTO = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                inicio,
   input  logic [N_CARRILES-1:0]               falsa,
   input  logic [N_CARRILES-1:0]               habilitado,
   output logic                                A,
   output logic                                L,
   output logic                                Y,
   output logic                                B,
   output logic [2:0]                          estado,
   output logic [N_CARRILES-1:0]               carril_falso,
   output logic [$clog2(MAX_FALSAS+1)-1:0]     num_falsas,
   output logic                                valida,
   output logic                                abortada
);

   localparam int NF_W = $clog2(MAX_FALSAS + 1);

   localparam logic [2:0] REPOSO  = 3'd0;
   localparam logic [2:0] PUESTOS = 3'd1;
   localparam logic [2:0] LISTOS  = 3'd2;
   localparam logic [2:0] YA      = 3'd3;
   localparam logic [2:0] BOCINA  = 3'd4;

   localparam logic [CNT_W-1:0] CARGA_PUESTOS = CNT_W'(T_PUESTOS - 1);
   localparam logic [CNT_W-1:0] CARGA_LISTOS  = CNT_W'(T_LISTOS - 1);
   localparam logic [CNT_W-1:0] CARGA_YA      = CNT_W'(T_YA - 1);
   localparam logic [CNT_W-1:0] CARGA_BOCINA  = CNT_W'(T_BOCINA - 1);
   localparam logic [CNT_W-1:0] TIMER_UNO     = CNT_W'(1);
   localparam logic [NF_W-1:0]  NF_MAX        = NF_W'(MAX_FALSAS);
   localparam logic [NF_W-1:0]  NF_UNO        = NF_W'(1);

   logic [2:0]            estado_q,  estado_d;
   logic [CNT_W-1:0]      timer_q,   timer_d;
   logic [N_CARRILES-1:0] carril_q,  carril_d;
   logic [NF_W-1:0]       nf_q,      nf_d;
   logic                  abort_q,   abort_d;
   logic                  valida_q,  valida_d;
   logic [3:0]            lamps_q,   lamps_d;

   logic [N_CARRILES-1:0] f;
   logic                  hay_falsa;
   logic                  timer_cero;

   // Per-lane qualification: a disabled lane can never trigger a false start.
   generate
      for (genvar gi = 0; gi < N_CARRILES; gi++) begin : g_carril
         assign f[gi] = falsa[gi] & habilitado[gi];
      end
   endgenerate

   assign hay_falsa  = |f;
   assign timer_cero = (timer_q == '0);

   always_comb begin
      estado_d = estado_q;
      timer_d  = timer_cero ? timer_q : (timer_q - TIMER_UNO);
      carril_d = carril_q;
      nf_d     = nf_q;
      abort_d  = abort_q;

      case (estado_q)
         REPOSO: begin
            if (inicio) begin
               estado_d = PUESTOS;
               timer_d  = CARGA_PUESTOS;
               carril_d = '0;
               nf_d     = '0;
               abort_d  = 1'b0;
            end
         end
         PUESTOS, LISTOS: begin
            // A false start wins over timer expiry in the same cycle.
            if (hay_falsa) begin
               estado_d = BOCINA;
               timer_d  = CARGA_BOCINA;
               carril_d = carril_q | f;
               nf_d     = (nf_q == NF_MAX) ? nf_q : (nf_q + NF_UNO);
            end else if (timer_cero) begin
               if (estado_q == PUESTOS) begin
                  estado_d = LISTOS;
                  timer_d  = CARGA_LISTOS;
               end else begin
                  estado_d = YA;
                  timer_d  = CARGA_YA;
               end
            end
         end
         YA: begin
            if (timer_cero) begin
               estado_d = REPOSO;
            end
         end
         BOCINA: begin
            if (timer_cero) begin
               if (AUTO_REINTENTO != 0 && nf_q < NF_MAX) begin
                  estado_d = PUESTOS;
                  timer_d  = CARGA_PUESTOS;
               end else begin
                  estado_d = REPOSO;
                  if (AUTO_REINTENTO != 0) begin
                     abort_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            estado_d = REPOSO;
            timer_d  = '0;
         end
      endcase
   end

   // Registered lamp and valida outputs track the next state so they line up with estado.
   always_comb begin
      lamps_d  = 4'b0000;
      case (estado_d)
         PUESTOS: lamps_d = 4'b1000;
         LISTOS:  lamps_d = 4'b0100;
         YA:      lamps_d = 4'b0010;
         BOCINA:  lamps_d = 4'b0001;
         default: lamps_d = 4'b0000;
      endcase
      valida_d = (estado_d == YA) && (estado_q != YA);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= REPOSO;
         timer_q  <= '0;
         carril_q <= '0;
         nf_q     <= '0;
         abort_q  <= 1'b0;
         valida_q <= 1'b0;
         lamps_q  <= 4'b0000;
      end else begin
         estado_q <= estado_d;
         timer_q  <= timer_d;
         carril_q <= carril_d;
         nf_q     <= nf_d;
         abort_q  <= abort_d;
         valida_q <= valida_d;
         lamps_q  <= lamps_d;
      end
   end

   assign A            = lamps_q[3];
   assign L            = lamps_q[2];
   assign Y            = lamps_q[1];
   assign B            = lamps_q[0];
   assign estado       = estado_q;
   assign carril_falso = carril_q;
   assign num_falsas   = nf_q;
   assign valida       = valida_q;
   assign abortada     = abort_q;

endmodule

// File: tb/tb_arranque_carrera_n.sv
// Directed bench for the race-start sequencer: three instances (defaults, auto-retry, 1-cycle
// phases) share stimulus; a scoreboard queue holds per-cycle expectations for the instance under test.
module tb_arranque_carrera_n;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       inicio = 1'b0;
   logic [3:0] falsa = 4'b0000;
   logic [3:0] habilitado = 4'b1111;

   logic [3:0] lamps [3];
   logic [2:0] est   [3];
   logic [3:0] cf    [3];
   logic [1:0] nf    [3];
   logic       val   [3];
   logic       ab    [3];

   always #5 clk = ~clk;

   arranque_carrera_n u_def (
      .clk(clk), .reset(reset), .inicio(inicio), .falsa(falsa), .habilitado(habilitado),
      .A(lamps[0][3]), .L(lamps[0][2]), .Y(lamps[0][1]), .B(lamps[0][0]), .estado(est[0]),
      .carril_falso(cf[0]), .num_falsas(nf[0]), .valida(val[0]), .abortada(ab[0]));

   arranque_carrera_n #(.AUTO_REINTENTO(1)) u_auto (
      .clk(clk), .reset(reset), .inicio(inicio), .falsa(falsa), .habilitado(habilitado),
      .A(lamps[1][3]), .L(lamps[1][2]), .Y(lamps[1][1]), .B(lamps[1][0]), .estado(est[1]),
      .carril_falso(cf[1]), .num_falsas(nf[1]), .valida(val[1]), .abortada(ab[1]));

   arranque_carrera_n #(.T_PUESTOS(1), .T_LISTOS(1), .T_YA(1), .T_BOCINA(1)) u_t1 (
      .clk(clk), .reset(reset), .inicio(inicio), .falsa(falsa), .habilitado(habilitado),
      .A(lamps[2][3]), .L(lamps[2][2]), .Y(lamps[2][1]), .B(lamps[2][0]), .estado(est[2]),
      .carril_falso(cf[2]), .num_falsas(nf[2]), .valida(val[2]), .abortada(ab[2]));

   typedef struct {
      int          dut;
      int          test;
      int          idx;
      logic [14:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cur_dut  = 0;
   int   cur_test = 0;
   int   step_n   = 0;
   logic [3:0] hab_cur = 4'b1111;

   localparam logic [3:0] LP = 4'b1000;
   localparam logic [3:0] LL = 4'b0100;
   localparam logic [3:0] LY = 4'b0010;
   localparam logic [3:0] LB = 4'b0001;
   localparam logic [3:0] L0 = 4'b0000;

   // Inputs for one cycle plus the outputs expected right after the following rising edge.
   task automatic step(input logic r, input logic ini, input logic [3:0] f,
                       input logic [3:0] lmp, input logic [2:0] st, input logic [3:0] c,
                       input logic [1:0] n, input logic v, input logic a);
      exp_t e;
      @(negedge clk);
      reset      = r;
      inicio     = ini;
      falsa      = f;
      habilitado = hab_cur;
      e.dut  = cur_dut;
      e.test = cur_test;
      e.idx  = step_n;
      e.v    = {lmp, st, c, n, v, a};
      exp_q.push_back(e);
      step_n++;
   endtask

   // Monitor: the DUT presents a new output set every cycle; compare just after each edge.
   initial begin
      exp_t        e;
      logic [14:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {lamps[e.dut], est[e.dut], cf[e.dut], nf[e.dut], val[e.dut], ab[e.dut]};
            n_checks++;
            if (act === e.v) begin
               n_pass++;
               $display("chk dut%0d t%0d s%0d out=%h ok", e.dut, e.test, e.idx, act);
            end else begin
               $display("FAIL dut%0d t%0d s%0d outputs got=%h expected=%h",
                        e.dut, e.test, e.idx, act, e.v);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Test 1: clean start on defaults.
      cur_dut = 0; cur_test = 1; hab_cur = 4'b1111;
      step(1, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (6) step(0, 0, 4'h0, LL, 3'd2, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'h0, LY, 3'd3, 4'h0, 2'd0, 1, 0);
      step(0, 0, 4'h0, LY, 3'd3, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);

      // Test 2: lane 2 moves in LISTOS cycle 3; falsa ignored during the horn.
      cur_test = 2;
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 4'h0, LL, 3'd2, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'b0100, LB, 3'd4, 4'b0100, 2'd1, 0, 0);
      repeat (2) step(0, 0, 4'hF, LB, 3'd4, 4'b0100, 2'd1, 0, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'b0100, 2'd1, 0, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'b0100, 2'd1, 0, 0);

      // Test 3: masked lane ignored; enabled lane in last LISTOS cycle beats expiry.
      cur_test = 3; hab_cur = 4'b1011;
      step(0, 1, 4'b0100, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 4'b0100, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (6) step(0, 0, 4'b0100, LL, 3'd2, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'b0001, LB, 3'd4, 4'b0001, 2'd1, 0, 0);
      repeat (2) step(0, 0, 4'h0, LB, 3'd4, 4'b0001, 2'd1, 0, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'b0001, 2'd1, 0, 0);
      step(1, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);

      // Test 4: reset mid-LISTOS wins over inicio, then a fresh start.
      cur_test = 4; hab_cur = 4'b1111;
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (2) step(0, 0, 4'h0, LL, 3'd2, 4'h0, 2'd0, 0, 0);
      step(1, 1, 4'hF, L0, 3'd0, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'h0, LL, 3'd2, 4'h0, 2'd0, 0, 0);

      // Test 5: auto-retry, two false starts then abort; new inicio clears flags.
      cur_dut = 1; cur_test = 5;
      step(1, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'b0010, LB, 3'd4, 4'b0010, 2'd1, 0, 0);
      repeat (2) step(0, 0, 4'h0, LB, 3'd4, 4'b0010, 2'd1, 0, 0);
      step(0, 0, 4'h0, LP, 3'd1, 4'b0010, 2'd1, 0, 0);
      step(0, 0, 4'b1000, LB, 3'd4, 4'b1010, 2'd2, 0, 0);
      repeat (2) step(0, 0, 4'h0, LB, 3'd4, 4'b1010, 2'd2, 0, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'b1010, 2'd2, 0, 1);
      step(0, 0, 4'h0, L0, 3'd0, 4'b1010, 2'd2, 0, 1);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      step(1, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);

      // Test 6: one-cycle phases; inicio held through YA does not restart early.
      cur_dut = 2; cur_test = 6;
      step(1, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LL, 3'd2, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LY, 3'd3, 4'h0, 2'd0, 1, 0);
      step(0, 1, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'h0, LL, 3'd2, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'h0, LY, 3'd3, 4'h0, 2'd0, 1, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'h0, 2'd0, 0, 0);
      step(0, 1, 4'h0, LP, 3'd1, 4'h0, 2'd0, 0, 0);
      step(0, 0, 4'b0001, LB, 3'd4, 4'b0001, 2'd1, 0, 0);
      step(0, 0, 4'h0, L0, 3'd0, 4'b0001, 2'd1, 0, 0);

      @(negedge clk);
      reset = 1'b0; inicio = 1'b0; falsa = 4'h0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: pending expectations got=%0d expected=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
